// File: rtl/sysarr_result_collector.sv
// Drain-side collector for the 3x3 systolic array: samples edge result ports on a fixed
// schedule after start, then streams the 3x3 matrix row-major. Option macro: SYSCOL_OVERRUN_ERR_EN.
module sysarr_result_collector #(
   parameter int N         = 32,
   parameter int DRAIN_LAT = 5
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic [N-1:0] c53,
   input  logic [N-1:0] c54,
   input  logic [N-1:0] c55,
   input  logic [N-1:0] c35,
   input  logic [N-1:0] c45,
   output logic         busy,
   output logic [N-1:0] out_data,
   output logic [3:0]   out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         err
);

   localparam int CW = $clog2(DRAIN_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_CAP_A, S_CAP_B, S_CAP_C, S_STREAM
   } state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [N-1:0]   r_mat [9];
   logic           r_busy;
   logic [N-1:0]   r_data;
   logic [3:0]     r_idx;
   logic           r_valid;
   logic           r_last;

   logic           w_xfer;
   logic [3:0]     w_idx_nxt;

   assign w_xfer    = r_valid & out_ready;
   assign w_idx_nxt = r_idx + 4'd1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_data  <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         for (int i = 0; i < 9; i++) r_mat[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_WAIT;
                  r_cnt   <= CW'(1);
                  r_busy  <= 1'b1;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(DRAIN_LAT - 1)) r_state <= S_CAP_A;
            end
            // Each wavefront exits the array one cycle after the previous one.
            S_CAP_A: begin
               r_mat[0] <= c55;
               r_mat[1] <= c45;
               r_mat[2] <= c35;
               r_mat[3] <= c54;
               r_mat[6] <= c53;
               r_state  <= S_CAP_B;
            end
            S_CAP_B: begin
               r_mat[4] <= c55;
               r_mat[5] <= c45;
               r_mat[7] <= c54;
               r_state  <= S_CAP_C;
            end
            S_CAP_C: begin
               r_mat[8] <= c55;
               r_state  <= S_STREAM;
               r_valid  <= 1'b1;
               r_idx    <= '0;
               r_data   <= r_mat[0];
               r_last   <= 1'b0;
            end
            S_STREAM: begin
               if (w_xfer) begin
                  if (r_idx == 4'd8) begin
                     r_state <= S_IDLE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_last  <= 1'b0;
                     r_idx   <= '0;
                     r_data  <= '0;
                  end else begin
                     r_idx  <= w_idx_nxt;
                     r_data <= r_mat[w_idx_nxt];
                     r_last <= (w_idx_nxt == 4'd8);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SYSCOL_OVERRUN_ERR_EN
   logic r_err;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)              r_err <= 1'b0;
      else if (start && r_busy)  r_err <= 1'b1;
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign busy      = r_busy;
   assign out_data  = r_data;
   assign out_idx   = r_idx;
   assign out_valid = r_valid;
   assign out_last  = r_last;

endmodule

// File: tb/tb_sysarr_result_collector.sv
// Scoreboard bench for sysarr_result_collector: stub array drives edge ports on the capture
// schedule; a negedge monitor pops expected elements on each accepted transfer.
module tb_sysarr_result_collector;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start5 = 1'b0, start7 = 1'b0;
   logic [31:0] c53 = '0, c54 = '0, c55 = '0, c35 = '0, c45 = '0;
   logic        out_ready = 1'b1;

   logic        busy5, busy7, valid5, valid7, last5, last7, err5, err7;
   logic [31:0] data5, data7;
   logic [3:0]  idx5, idx7;

   bit          sel = 1'b0;
   bit          stall_mode = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;

   logic        mon_busy, mon_valid, mon_last, mon_err;
   logic [31:0] mon_data;
   logic [3:0]  mon_idx;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  i;
      logic        l;
   } exp_t;
   exp_t sb[$];

   logic [31:0] mat_a   [9] = '{32'd30, 32'd36, 32'd42, 32'd66, 32'd81, 32'd96, 32'd102, 32'd126, 32'd150};
   logic [31:0] mat_id  [9] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
   logic [31:0] mat_ff  [9] = '{9{32'hFFFF_FFFF}};

   always #5 clock = ~clock;

   sysarr_result_collector #(.N(32), .DRAIN_LAT(5)) u_dut5 (
      .clock(clock), .reset_n(reset_n), .start(start5),
      .c53(c53), .c54(c54), .c55(c55), .c35(c35), .c45(c45),
      .busy(busy5), .out_data(data5), .out_idx(idx5), .out_valid(valid5),
      .out_ready(out_ready), .out_last(last5), .err(err5)
   );

   sysarr_result_collector #(.N(32), .DRAIN_LAT(7)) u_dut7 (
      .clock(clock), .reset_n(reset_n), .start(start7),
      .c53(c53), .c54(c54), .c55(c55), .c35(c35), .c45(c45),
      .busy(busy7), .out_data(data7), .out_idx(idx7), .out_valid(valid7),
      .out_ready(out_ready), .out_last(last7), .err(err7)
   );

   assign mon_busy  = sel ? busy7  : busy5;
   assign mon_valid = sel ? valid7 : valid5;
   assign mon_last  = sel ? last7  : last5;
   assign mon_err   = sel ? err7   : err5;
   assign mon_data  = sel ? data7  : data5;
   assign mon_idx   = sel ? idx7   : idx5;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else n_pass++;
   endfunction

   // Ready pattern: always 1, or one cycle on / two off.
   initial begin
      int cyc = 0;
      forever begin
         @(posedge clock); #1;
         cyc++;
         out_ready = stall_mode ? ((cyc % 3) == 0) : 1'b1;
      end
   end

   // Monitor: inputs change at posedge+1, so the negedge view is what the next edge samples.
   initial begin
      bit          prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      logic [3:0]  prev_idx = '0;
      exp_t        e;
      forever begin
         @(negedge clock);
         if (prev_stall) begin
            chk("stall_valid_held", {63'd0, mon_valid}, 64'd1);
            chk("stall_hold", {28'd0, mon_idx, mon_data}, {28'd0, prev_idx, prev_data});
         end
         if (mon_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", {27'd0, mon_idx, mon_data, mon_last}, 64'd0 - 64'd1);
            end else begin
               e = sb.pop_front();
               chk("element", {27'd0, mon_data, mon_idx, mon_last}, {27'd0, e.d, e.i, e.l});
               $display("xfer idx=%0d data=0x%08h last=%0d", mon_idx, mon_data, mon_last);
            end
         end
         prev_stall = mon_valid && !out_ready;
         prev_data  = mon_data;
         prev_idx   = mon_idx;
      end
   end

   task automatic set_start(input logic v);
      if (sel) start7 = v;
      else     start5 = v;
   endtask

   task automatic drive_ports(input int k, input int dl, input logic [31:0] m[9]);
      c53 = 32'hDEAD_0053 ^ 32'(k);
      c54 = 32'hDEAD_0054 ^ 32'(k);
      c55 = 32'hDEAD_0055 ^ 32'(k);
      c35 = 32'hDEAD_0035 ^ 32'(k);
      c45 = 32'hDEAD_0045 ^ 32'(k);
      if (k == dl) begin
         c55 = m[0]; c45 = m[1]; c35 = m[2]; c54 = m[3]; c53 = m[6];
      end else if (k == dl + 1) begin
         c55 = m[4]; c45 = m[5]; c54 = m[7];
      end else if (k == dl + 2) begin
         c55 = m[8];
      end
   endtask

   task automatic run(input logic [31:0] m[9], input int ovr_k);
      int   dl = sel ? 7 : 5;
      exp_t e;
      for (int i = 0; i < 9; i++) begin
         e.d = m[i];
         e.i = 4'(i);
         e.l = (i == 8);
         sb.push_back(e);
      end
      set_start(1'b1);
      @(posedge clock); #1;
      set_start(1'b0);
      chk("busy_after_start", {63'd0, mon_busy}, 64'd1);
      for (int k = 1; k <= dl + 2; k++) begin
         set_start(k == ovr_k);
         drive_ports(k, dl, m);
         @(posedge clock); #1;
         if (k == dl + 1) chk("valid_before_stream", {63'd0, mon_valid}, 64'd0);
         if (k == dl + 2) chk("valid_at_stream", {63'd0, mon_valid}, 64'd1);
      end
      set_start(1'b0);
      drive_ports(0, dl, m);
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0 && !mon_busy) begin
            done = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      chk("drain_done", {63'd0, done}, 64'd1);
      chk("idle_after_drain", {61'd0, mon_busy, mon_valid, mon_last}, 64'd0);
      sb.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_err;
`ifdef SYSCOL_OVERRUN_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      #12;
      chk("rst_busy",  {63'd0, mon_busy},  64'd0);
      chk("rst_valid", {63'd0, mon_valid}, 64'd0);
      chk("rst_last",  {63'd0, mon_last},  64'd0);
      chk("rst_err",   {63'd0, mon_err},   64'd0);
      chk("rst_data",  {32'd0, mon_data},  64'd0);
      chk("rst_idx",   {60'd0, mon_idx},   64'd0);
      @(posedge clock); #1 reset_n = 1'b1;
      repeat (2) @(posedge clock); #1;

      // 1: A*A with out_ready held high
      run(mat_a, 0);
      wait_drain();
      chk("err_clean_run", {63'd0, mon_err}, 64'd0);

      // 2: same data under a 1-on/2-off ready pattern
      stall_mode = 1'b1;
      @(posedge clock); #1;
      run(mat_a, 0);
      wait_drain();
      stall_mode = 1'b0;

      // 3: full-width values
      @(posedge clock); #1;
      run(mat_ff, 0);
      wait_drain();

      // 4: reset mid-WAIT, then identity run
      set_start(1'b1);
      @(posedge clock); #1;
      set_start(1'b0);
      @(posedge clock); #1;
      reset_n = 1'b0;
      #2;
      chk("async_rst_busy",  {63'd0, mon_busy},  64'd0);
      chk("async_rst_valid", {63'd0, mon_valid}, 64'd0);
      @(posedge clock); #1 reset_n = 1'b1;
      @(posedge clock); #1;
      run(mat_id, 0);
      wait_drain();

      // 5: overrun start two edges after the first
      @(posedge clock); #1;
      run(mat_a, 2);
      wait_drain();
      repeat (20) @(posedge clock);
      #1;
      chk("no_second_run", {62'd0, mon_busy, mon_valid}, 64'd0);
      chk("overrun_err", {63'd0, mon_err}, {63'd0, exp_err});
      do_reset();
      chk("err_cleared", {63'd0, mon_err}, 64'd0);

      // 6: DRAIN_LAT=7 instance
      sel = 1'b1;
      @(posedge clock); #1;
      run(mat_a, 0);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
